// File: rtl/dds_pulse_sequencer.sv
// AD9914 strobe sequencer: runs a burst of PRIs from latched config, emitting registered update/pre-trig/trig/osk strobes.
// Optional CONT_MODE_EN: burst_count==0 runs continuously until stop.
module dds_pulse_sequencer #(
  parameter int STROBE_W = 4,
  parameter int MIN_LEAD = 24,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] prt_period,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [15:0]      pre_lead,
  input  logic [15:0]      burst_count,
  input  logic             ct_en,
  output logic             ad9914_update_1,
  output logic             ad9914_update_2,
  output logic             ad9914_pre_trig_1,
  output logic             ad9914_trig_1,
  output logic             ad9914_osk_2_temp,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [15:0]      pri_idx
);
  localparam int CW1 = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  // Assertion is immediate; release is aligned to clk through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pri_cnt_q, pri_cnt_d;
  logic [15:0]        pri_idx_q, pri_idx_d;
  logic [CNT_W-1:0]   prt_q, prt_d, pw_q, pw_d;
  logic [15:0]        pl_q, pl_d, bc_q, bc_d;
  logic               ct_q, ct_d;
  logic               upd1_q, upd1_d, upd2_q, upd2_d, pre_q, pre_d;
  logic               trig_q, trig_d, osk_q, osk_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CNT_W:0]     need_w;
  logic               bc_ok, cfg_ok, last_pri, run_d, head_d;
  logic [CNT_W:0]     cnt_x, lo_x, hi_x;

  always_comb begin
    need_w = {1'b0, pulse_width} + CW1'(pre_lead) + CW1'(2);
`ifdef CONT_MODE_EN
    bc_ok    = 1'b1;
    last_pri = (bc_q != 16'd0) && (pri_idx_q == bc_q - 16'd1);
`else
    bc_ok    = (burst_count != 16'd0);
    last_pri = (pri_idx_q == bc_q - 16'd1);
`endif
    cfg_ok = bc_ok && (pulse_width != '0) && (pre_lead >= 16'(MIN_LEAD)) &&
             ({1'b0, prt_period} >= need_w);
  end

  always_comb begin
    state_d   = state_q;
    pri_cnt_d = pri_cnt_q;
    pri_idx_d = pri_idx_q;
    prt_d     = prt_q;
    pw_d      = pw_q;
    pl_d      = pl_q;
    bc_d      = bc_q;
    ct_d      = ct_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d   = S_RUN;
            pri_cnt_d = '0;
            pri_idx_d = 16'd0;
            prt_d     = prt_period;
            pw_d      = pulse_width;
            pl_d      = pre_lead;
            bc_d      = burst_count;
            ct_d      = ct_en;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pri_cnt_q == prt_q - CNT_W'(1)) begin
          if (last_pri) begin
            state_d = S_FINISH;
          end else begin
            pri_cnt_d = '0;
            // Wrap skips 0 so update_1 fires only on the very first PRI.
            pri_idx_d = (pri_idx_q == 16'hFFFF) ? 16'd1 : pri_idx_q + 16'd1;
          end
        end else begin
          pri_cnt_d = pri_cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from next-state values so the flopped outputs line up with pri_cnt_q.
  always_comb begin
    run_d  = (state_d == S_RUN);
    head_d = (pri_cnt_d < CNT_W'(STROBE_W));
    cnt_x  = {1'b0, pri_cnt_d};
    lo_x   = CW1'(pl_d);
    hi_x   = lo_x + {1'b0, pw_d};
    upd1_d = run_d && head_d && (pri_idx_d == 16'd0);
    upd2_d = upd1_d && ct_d;
    pre_d  = run_d && head_d && (pri_idx_d != 16'd0);
    trig_d = run_d && (cnt_x >= lo_x) && (cnt_x < hi_x);
    osk_d  = trig_d && ct_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= S_IDLE;
      pri_cnt_q <= '0;
      pri_idx_q <= '0;
      prt_q     <= '0;
      pw_q      <= '0;
      pl_q      <= '0;
      bc_q      <= '0;
      ct_q      <= 1'b0;
      upd1_q    <= 1'b0;
      upd2_q    <= 1'b0;
      pre_q     <= 1'b0;
      trig_q    <= 1'b0;
      osk_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pri_cnt_q <= pri_cnt_d;
      pri_idx_q <= pri_idx_d;
      prt_q     <= prt_d;
      pw_q      <= pw_d;
      pl_q      <= pl_d;
      bc_q      <= bc_d;
      ct_q      <= ct_d;
      upd1_q    <= upd1_d;
      upd2_q    <= upd2_d;
      pre_q     <= pre_d;
      trig_q    <= trig_d;
      osk_q     <= osk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ad9914_update_1   = upd1_q;
  assign ad9914_update_2   = upd2_q;
  assign ad9914_pre_trig_1 = pre_q;
  assign ad9914_trig_1     = trig_q;
  assign ad9914_osk_2_temp = osk_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign cfg_err           = err_q;
  assign pri_idx           = pri_idx_q;
endmodule

// File: tb/tb_dds_pulse_sequencer.sv
// Scoreboard bench for dds_pulse_sequencer: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_dds_pulse_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, ct_en = 1'b0;
  logic [31:0] prt_period = '0, pulse_width = '0;
  logic [15:0] pre_lead = '0, burst_count = '0;
  logic        u1, u2, pt, tr, osk, busy, done, cfg_err;
  logic [15:0] pri_idx;

  always #5 clk = ~clk;

  dds_pulse_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .prt_period(prt_period), .pulse_width(pulse_width), .pre_lead(pre_lead),
    .burst_count(burst_count), .ct_en(ct_en),
    .ad9914_update_1(u1), .ad9914_update_2(u2), .ad9914_pre_trig_1(pt),
    .ad9914_trig_1(tr), .ad9914_osk_2_temp(osk),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pri_idx(pri_idx)
  );

  typedef struct packed {
    logic u1, u2, pt, tr, osk, busy, done, err;
    logic [15:0] idx;
  } obs_t;

  obs_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_idx = 0;
  obs_t mon_o, mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    mon_o = '{u1, u2, pt, tr, osk, busy, done, cfg_err, pri_idx};
    if (mon_o.busy || mon_o.done || mon_o.err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output at %0t", mon_o, $time);
      end else begin
        mon_e = q.pop_front();
        chk("obs", 32'(mon_o), 32'(mon_e));
      end
    end else begin
      chk("idle_strobes", {27'd0, u1, u2, pt, tr, osk}, 32'd0);
    end
  end

  // upto<0: full burst plus the FINISH cycle; upto>=0: outputs end after cycle upto (stop/reset).
  task automatic push_burst(input int prt, input int pw, input int pl, input int nb,
                            input bit ct, input int upto);
    int last;
    obs_t e;
    last = (upto >= 0) ? upto : nb * prt - 1;
    for (int k = 0; k <= last; k++) begin
      int pri, cnt;
      pri = k / prt;
      cnt = k % prt;
      e = '0;
      e.u1   = (pri == 0) && (cnt < 4);
      e.u2   = e.u1 && ct;
      e.pt   = (pri != 0) && (cnt < 4);
      e.tr   = (cnt >= pl) && (cnt < pl + pw);
      e.osk  = e.tr && ct;
      e.busy = 1'b1;
      e.idx  = 16'(pri);
      q.push_back(e);
    end
    exp_idx = last / prt;
    if (upto < 0) begin
      e = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      e.idx  = 16'(nb - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_err();
    obs_t e;
    e = '0;
    e.err = 1'b1;
    e.idx = 16'(exp_idx);
    q.push_back(e);
  endtask

  // Entered at a negedge; returns at the negedge of the first cycle after the start edge.
  task automatic issue(input int prt, input int pw, input int pl, input int bc,
                       input bit ct, input bit stp);
    prt_period  = 32'(prt);
    pulse_width = 32'(pw);
    pre_lead    = 16'(pl);
    burst_count = 16'(bc);
    ct_en       = ct;
    start       = 1'b1;
    stop        = stp;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_strobes", {27'd0, u1, u2, pt, tr, osk}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, cfg_err}, 32'd0);
    chk("rst_idx", 32'(pri_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(4);

    // Basic 3-PRI burst, then CT burst with inputs scrambled and a stray start mid-run.
    push_burst(100, 10, 30, 3, 1'b0, -1);
    issue(100, 10, 30, 3, 1'b0, 1'b0);
    wait_cycles(305);
    push_burst(100, 10, 30, 3, 1'b1, -1);
    issue(100, 10, 30, 3, 1'b1, 1'b0);
    prt_period = 32'd5; pulse_width = 32'd0; pre_lead = 16'd0; burst_count = 16'd1; ct_en = 1'b0;
    wait_cycles(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(260);

    // Rejections and the minimum accepted period.
    push_err();
    issue(100, 10, 20, 3, 1'b0, 1'b0);
    wait_cycles(4);
    push_err();
    issue(41, 10, 30, 3, 1'b0, 1'b0);
    wait_cycles(4);
    push_err();
    issue(100, 0, 30, 3, 1'b0, 1'b0);
    wait_cycles(4);
    push_burst(42, 10, 30, 2, 1'b0, -1);
    issue(42, 10, 30, 2, 1'b0, 1'b0);
    wait_cycles(90);

    // Stop coinciding with the last PRI end: no done, index holds.
    push_burst(42, 10, 30, 2, 1'b0, 83);
    issue(42, 10, 30, 2, 1'b0, 1'b0);
    wait_cycles(83);
    pulse_stop();
    chk("stop_last_busy", 32'(busy), 32'd0);
    chk("stop_last_done", 32'(done), 32'd0);
    wait_cycles(4);
    chk("stop_last_idx", 32'(pri_idx), 32'd1);

    // Stop mid-trig in PRI1.
    push_burst(100, 10, 30, 3, 1'b0, 135);
    issue(100, 10, 30, 3, 1'b0, 1'b0);
    wait_cycles(135);
    pulse_stop();
    chk("stop_trig", 32'(tr), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    wait_cycles(4);

    // Start and stop together in IDLE: start wins.
    push_burst(42, 10, 30, 1, 1'b0, -1);
    issue(42, 10, 30, 1, 1'b0, 1'b1);
    wait_cycles(48);

    // Async reset between edges while trig is high.
    push_burst(100, 10, 30, 3, 1'b0, 33);
    issue(100, 10, 30, 3, 1'b0, 1'b0);
    wait_cycles(33);
    #2 rst = 1'b0;
    #1;
    chk("arst_strobes", {27'd0, u1, u2, pt, tr, osk}, 32'd0);
    chk("arst_flags", {29'd0, busy, done, cfg_err}, 32'd0);
    chk("arst_idx", 32'(pri_idx), 32'd0);
    exp_idx = 0;
    @(negedge clk);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(4);
    chk("post_rst_busy", 32'(busy), 32'd0);
    push_burst(42, 10, 30, 1, 1'b1, -1);
    issue(42, 10, 30, 1, 1'b1, 1'b0);
    wait_cycles(48);

`ifdef CONT_MODE_EN
    push_burst(50, 10, 30, 0, 1'b0, 249);
    issue(50, 10, 30, 0, 1'b0, 1'b0);
    wait_cycles(249);
    pulse_stop();
    chk("cont_stop_busy", 32'(busy), 32'd0);
    wait_cycles(4);
`else
    push_err();
    issue(100, 10, 30, 0, 1'b0, 1'b0);
    wait_cycles(4);
`endif

    wait_cycles(5);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dds_pulse_sequencer.md
Name: dds_pulse_sequencer

Overview:
- Timing source directly upstream of the work-flow stage.
- Generates the AD9914 strobe set per burst: `ad9914_update_1`, `ad9914_update_2`, `ad9914_pre_trig_1`, `ad9914_trig_1`, `ad9914_osk_2_temp`. The work-flow stage derives tv/tr/tr_pwr/lo/osk gating from these edges.
- Runs a burst of N pulse-repetition intervals (PRIs) from latched configuration; supports abort and reports status.

Parameters:
- STROBE_W, 4, high width in clk cycles of `update_1`, `update_2` and `pre_trig_1` pulses.
- MIN_LEAD, 24, minimum accepted `pre_lead`; guarantees the downstream tr_pwr settle counter (>20) expires before trig.
- CNT_W, 32, width of `prt_period` / `pulse_width` / internal PRI counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- stop  in  1  single-cycle abort request.
- prt_period  in  CNT_W  PRI length in cycles.
- pulse_width  in  CNT_W  trig high time in cycles.
- pre_lead  in  16  cycles from PRI start to trig rise.
- burst_count  in  16  number of PRIs per burst.
- ct_en  in  1  CT burst: assert `update_2` at burst start and drive `osk_2_temp`.
- ad9914_update_1  out  1  burst-start strobe.
- ad9914_update_2  out  1  CT-start strobe.
- ad9914_pre_trig_1  out  1  PRI-start strobe for PRIs 2..N.
- ad9914_trig_1  out  1  transmit window.
- ad9914_osk_2_temp  out  1  OSK request, equals trig window when CT burst.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at normal burst completion.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pri_idx  out  16  current PRI index, 0-based.

Behaviour:
- Reset (async, `rst`=0): all outputs 0, state IDLE, counters 0. Deassertion is synchronised with a 2-flop stage internally.
- States: IDLE, RUN, FINISH.
- IDLE, start=1: validate, then latch all config inputs and ct_en.
  - Valid iff burst_count≠0, pulse_width≥1, pre_lead≥MIN_LEAD, prt_period ≥ pre_lead+pulse_width+2. Compare in CNT_W+1 bits so there is no overflow.
  - Invalid: cfg_err pulses the next cycle; remain IDLE.
  - Valid: enter RUN next cycle with pri_cnt=0, pri_idx=0.
- RUN: pri_cnt increments each cycle, 0..prt_period-1.
  - PRI start strobe: cycles pri_cnt 0..STROBE_W-1 drive `update_1` if pri_idx==0, else `pre_trig_1`.
  - `update_2` equals `update_1` when the latched ct_en=1, otherwise 0.
  - `trig_1`: high for pri_cnt in [pre_lead, pre_lead+pulse_width-1].
  - `osk_2_temp`: equals trig_1 AND latched ct_en.
  - All strobes are registered outputs, with no combinational path from inputs.
  - At pri_cnt==prt_period-1:
    - If pri_idx==burst_count-1, go to FINISH.
    - Else pri_cnt←0 and pri_idx+1.
- FINISH: one cycle; done=1; then IDLE. pri_idx holds its last value until the next accepted start.
- start while busy: ignored.
- stop, any state except IDLE:
  - Next cycle all strobes are 0, including trig_1 mid-window, which produces the trig falling edge downstream.
  - State goes to IDLE; done is not pulsed.
- stop and start in the same cycle in IDLE: start is processed and stop is ignored.
- stop on the same cycle as the last PRI end: stop wins; done is not pulsed.
- Latched config is immune to input changes during RUN.
- Reset mid-burst: outputs clear immediately (async).

Optional Feature:
- CONT_MODE_EN
  - Defined: burst_count==0 is valid and means continuous. PRIs repeat until stop. pri_idx wraps 0xFFFF→1, never returning to 0, so update_1 occurs only once. done never pulses.
  - Undefined: burst_count==0 gives cfg_err.

Test Plan:
- prt_period=100, pulse_width=10, pre_lead=30, burst_count=3, ct_en=0, start →
  - update_1 high cycles 0–3 of PRI0.
  - pre_trig_1 high cycles 0–3 of PRI1 and PRI2.
  - trig_1 high cycles 30–39 in each PRI.
  - done one cycle after cycle 299; update_2 and osk_2_temp stay 0.
- Same configuration with ct_en=1 → update_2 identical to update_1; osk_2_temp identical to trig_1.
- Rejected starts:
  - pre_lead=20 → cfg_err pulse, busy stays 0.
  - prt_period=41, pre_lead=30, pulse_width=10 → cfg_err pulse.
  - prt_period=42 with the same values → accepted.
- stop at PRI1 cycle 35, with trig high → trig_1=0 the next cycle, busy=0, no done; a new start is then accepted normally.
- Async reset asserted mid-trig and between clock edges → all outputs 0 before the next edge; after release, IDLE.
- CONT_MODE_EN, burst_count=0, prt_period=50 → 5 consecutive PRIs, update_1 only in the first; stop ends the burst; without the macro, cfg_err.
